reg_read_stage: RTL and testbench
=================================

// Module: reg_read_stage
// PURPOSE
//  Register-read stage between the issue/select logic and the ALU execute stage.
//  - Accepts one issued uop per cycle and drives the physical-register-file read ports.
//  - Resolves each source operand by bypass from the execute forward bus, then the writeback
//    bus, then the PRF.
//  - Registers the completed exec_packet_t for execute_alu.
//  - Owns a 1-entry skid buffer so that issue backpressure is registered.
//  - Squashes wrong-path uops on a branch flush.
// PARAMETERS
//  XLEN       32  operand/result width
//  PREG_W     6   physical register index width (64 pregs; preg 0 hardwired zero)
//  ROB_IDX_W  5   ROB index width (32 entries, wraps)
// PORTS
//  clk            in   1          clock, all state updates on posedge
//  rst            in   1          asynchronous, active-high reset
//  iss_valid      in   1          issued uop present
//  iss_pkt        in   issue_packet_t  src1/2_preg, src1/2_used, dst_preg, imm_val, pc, opcode, alu_en, br_taken, rob_entry_idx
//  iss_ready      out  1          stage can accept a uop this cycle (registered)
//  prf_rs1_idx    out  PREG_W     PRF read port 1 index (= iss_pkt.src1_preg, comb)
//  prf_rs1_val    in   XLEN       PRF read port 1 data (same cycle)
//  prf_rs2_idx    out  PREG_W     PRF read port 2 index
//  prf_rs2_val    in   XLEN       PRF read port 2 data
//  fwd_valid      in   1          execute same-cycle result valid
//  fwd_dst        in   PREG_W     execute result destination preg
//  fwd_val        in   XLEN       execute result value
//  wb_valid       in   1          registered writeback to PRF valid (in flight this cycle)
//  wb_dst         in   PREG_W     writeback destination preg
//  wb_val         in   XLEN       writeback value
//  flush          in   1          branch-mispredict flush
//  flush_rob_idx  in   ROB_IDX_W  ROB index of the mispredicting branch
//  rob_head_idx   in   ROB_IDX_W  current ROB head (oldest), for age compare
//  ex_ready       in   1          execute accepts ex_pkt this cycle
//  ex_valid       out  1          ex_pkt valid
//  ex_pkt         out  exec_packet_t  resolved packet: src1_val, src2_val, imm_val, pc, opcode, alu_en, br_taken, dst_preg, rob_entry_idx
// BEHAVIOUR
//  - Reset (async): ex_valid=0, ex_pkt='0, skid_valid=0, skid='0, iss_ready=1. Reset overrides flush.
//  - Accept on iss_valid && iss_ready. Latency: accept in cycle N gives ex_valid in N+1 when the output
//    register is free or drains in N.
//  - Operand resolve, per source, evaluated in the accept cycle:
//    - !srcX_used or srcX_preg==0 -> 0.
//    - else fwd_valid && fwd_dst==preg -> fwd_val.
//    - else wb_valid && wb_dst==preg -> wb_val.
//    - else prf_rsX_val.
//    - Priority is fwd > wb > PRF. fwd/wb hits on dst 0 are ignored.
//  - Captured values are final. Held entries are never re-read or re-bypassed.
//  - Output register loads when !ex_valid || ex_ready.
//    - Source: skid if skid_valid, else the incoming accepted uop.
//    - If there is no source, ex_valid<=0.
//  - Skid:
//    - An accepted uop goes to skid when the output register is held (ex_valid && !ex_ready),
//      or when skid drains into the output register in the same cycle.
//    - Order is preserved: out is older than skid, which is older than incoming.
//  - iss_ready <= !(next skid_valid). Once skid fills, issue stalls from the next cycle on.
//  - Flush, same cycle as the flush pulse:
//    - Entries strictly younger than flush_rob_idx are dropped: out, skid, and the incoming uop.
//    - The branch itself (equal idx) and older entries are kept.
//    - Age: age(x) = (x - rob_head_idx) mod 2^ROB_IDX_W; younger iff age(x) > age(flush_rob_idx).
//    - Dropping out while skid survives moves skid into out next cycle.
//  - Simultaneous ex_ready and flush: the flush test applies to the entries left after this cycle's moves.
//    An entry drained into execute this cycle is not recalled.
//  - Simultaneous fwd and wb hit on the same preg: fwd wins, because it is the newer value.
//  - Wrap-around: the age compare must hold across the ROB index wrap (head=30, flush=1, entry=3 is younger).
// STRUCTURE
//  - Shared package backend_pkg:
//    - issue_packet_t and exec_packet_t.
//    - XLEN, PREG_W and ROB_IDX_W constants.
//    - Function rob_is_younger(idx, ref, head).
//  - Sub-module operand_bypass: combinational fwd/wb/PRF/zero mux, instantiated twice (src1, src2).
//  - This file holds the output register, the skid register, ready generation and flush filtering.
// TESTING
//  1. Back-to-back, no stall:
//     - PRF p5=0x11, p6=0x22; issue add(p5,p6) -> next cycle ex_valid=1, src1_val=0x11, src2_val=0x22.
//  2. Bypass priority:
//     - PRF p7=0x1, wb p7=0x2, fwd p7=0x3, all in the same cycle -> src1_val=0x3.
//     - Drop fwd -> src1_val=0x2.
//     - src1_preg=0 with fwd_dst=0 -> src1_val=0.
//  3. Stall/skid:
//     - ex_ready=0 with 3 uops A, B, C offered back-to-back -> A held in out, B in skid, iss_ready=0 from
//       the cycle after B is accepted, C not accepted.
//     - Raise ex_ready -> A, B, C delivered in order with no loss or duplication.
//  4. Flush filtering:
//     - head=0; out idx=4, skid idx=6, incoming idx=7; flush_rob_idx=5 -> out kept; skid and incoming dropped.
//     - Next cycle, iss_ready=1.
//  5. Wrap flush:
//     - head=30, flush_rob_idx=31; out idx=1 -> dropped.
//     - out idx=29 (age 31, younger) -> dropped.
//     - out idx=31 -> kept.
//  6. Async reset mid-stall:
//     - Assert rst between clock edges with out and skid full -> ex_valid=0 and iss_ready=1 immediately,
//       with no clock edge needed.

Source files
------------

// File: rtl/backend_pkg.sv
// Shared back-end types: issue/execute packets, widths, and the ROB age compare.
package backend_pkg;

  localparam int XLEN      = 32;
  localparam int PREG_W    = 6;
  localparam int ROB_IDX_W = 5;
  localparam int OPC_W     = 7;

  typedef struct packed {
    logic [PREG_W-1:0]    src1_preg;
    logic [PREG_W-1:0]    src2_preg;
    logic                 src1_used;
    logic                 src2_used;
    logic [PREG_W-1:0]    dst_preg;
    logic [XLEN-1:0]      imm_val;
    logic [XLEN-1:0]      pc;
    logic [OPC_W-1:0]     opcode;
    logic                 alu_en;
    logic                 br_taken;
    logic [ROB_IDX_W-1:0] rob_entry_idx;
  } issue_packet_t;

  typedef struct packed {
    logic [XLEN-1:0]      src1_val;
    logic [XLEN-1:0]      src2_val;
    logic [XLEN-1:0]      imm_val;
    logic [XLEN-1:0]      pc;
    logic [OPC_W-1:0]     opcode;
    logic                 alu_en;
    logic                 br_taken;
    logic [PREG_W-1:0]    dst_preg;
    logic [ROB_IDX_W-1:0] rob_entry_idx;
  } exec_packet_t;

  // Ages are distances from the ROB head, so the compare survives index wrap.
  function automatic logic rob_is_younger(input logic [ROB_IDX_W-1:0] idx,
                                          input logic [ROB_IDX_W-1:0] ref_idx,
                                          input logic [ROB_IDX_W-1:0] head);
    logic [ROB_IDX_W-1:0] a_idx;
    logic [ROB_IDX_W-1:0] a_ref;
    a_idx = idx - head;
    a_ref = ref_idx - head;
    return a_idx > a_ref;
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Single-operand resolve: zero, then execute forward, then writeback, then PRF data.
module operand_bypass
  import backend_pkg::*;
(
  input  logic              i_used,
  input  logic [PREG_W-1:0] i_preg,
  input  logic [XLEN-1:0]   i_prf_val,
  input  logic              i_fwd_valid,
  input  logic [PREG_W-1:0] i_fwd_dst,
  input  logic [XLEN-1:0]   i_fwd_val,
  input  logic              i_wb_valid,
  input  logic [PREG_W-1:0] i_wb_dst,
  input  logic [XLEN-1:0]   i_wb_val,
  output logic [XLEN-1:0]   o_val
);

  // Forward beats writeback: it carries the newer value for the same preg.
  always_comb begin
    o_val = i_prf_val;
    if (!i_used || (i_preg == '0)) begin
      o_val = '0;
    end else if (i_fwd_valid && (i_fwd_dst == i_preg)) begin
      o_val = i_fwd_val;
    end else if (i_wb_valid && (i_wb_dst == i_preg)) begin
      o_val = i_wb_val;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: operand resolve, output register with 1-entry skid, flush filtering.
module reg_read_stage
  import backend_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  issue_packet_t        iss_pkt,
  output logic                 iss_ready,
  output logic [PREG_W-1:0]    prf_rs1_idx,
  input  logic [XLEN-1:0]      prf_rs1_val,
  output logic [PREG_W-1:0]    prf_rs2_idx,
  input  logic [XLEN-1:0]      prf_rs2_val,
  input  logic                 fwd_valid,
  input  logic [PREG_W-1:0]    fwd_dst,
  input  logic [XLEN-1:0]      fwd_val,
  input  logic                 wb_valid,
  input  logic [PREG_W-1:0]    wb_dst,
  input  logic [XLEN-1:0]      wb_val,
  input  logic                 flush,
  input  logic [ROB_IDX_W-1:0] flush_rob_idx,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output exec_packet_t         ex_pkt
);

  logic         r_ex_valid;
  exec_packet_t r_ex_pkt;
  logic         r_skid_valid;
  exec_packet_t r_skid_pkt;
  logic         r_iss_ready;

  logic         w_accept;
  logic         w_out_load;
  logic [XLEN-1:0] w_src1_val;
  logic [XLEN-1:0] w_src2_val;
  exec_packet_t w_inc_pkt;
  logic         w_out_vld;
  exec_packet_t w_out_pkt;
  logic         w_skid_vld;
  exec_packet_t w_skid_pkt;

  assign prf_rs1_idx = iss_pkt.src1_preg;
  assign prf_rs2_idx = iss_pkt.src2_preg;
  assign w_accept    = iss_valid && r_iss_ready;
  assign w_out_load  = !r_ex_valid || ex_ready;

  operand_bypass u_src1 (
    .i_used(iss_pkt.src1_used), .i_preg(iss_pkt.src1_preg), .i_prf_val(prf_rs1_val),
    .i_fwd_valid(fwd_valid), .i_fwd_dst(fwd_dst), .i_fwd_val(fwd_val),
    .i_wb_valid(wb_valid), .i_wb_dst(wb_dst), .i_wb_val(wb_val), .o_val(w_src1_val)
  );

  operand_bypass u_src2 (
    .i_used(iss_pkt.src2_used), .i_preg(iss_pkt.src2_preg), .i_prf_val(prf_rs2_val),
    .i_fwd_valid(fwd_valid), .i_fwd_dst(fwd_dst), .i_fwd_val(fwd_val),
    .i_wb_valid(wb_valid), .i_wb_dst(wb_dst), .i_wb_val(wb_val), .o_val(w_src2_val)
  );

  always_comb begin
    w_inc_pkt.src1_val      = w_src1_val;
    w_inc_pkt.src2_val      = w_src2_val;
    w_inc_pkt.imm_val       = iss_pkt.imm_val;
    w_inc_pkt.pc            = iss_pkt.pc;
    w_inc_pkt.opcode        = iss_pkt.opcode;
    w_inc_pkt.alu_en        = iss_pkt.alu_en;
    w_inc_pkt.br_taken      = iss_pkt.br_taken;
    w_inc_pkt.dst_preg      = iss_pkt.dst_preg;
    w_inc_pkt.rob_entry_idx = iss_pkt.rob_entry_idx;
  end

  // Moves first (drain, skid->out, accept), then flush filters what is left.
  always_comb begin
    w_out_vld  = r_ex_valid;
    w_out_pkt  = r_ex_pkt;
    w_skid_vld = r_skid_valid;
    w_skid_pkt = r_skid_pkt;
    if (w_out_load) begin
      if (r_skid_valid) begin
        w_out_vld  = 1'b1;
        w_out_pkt  = r_skid_pkt;
        w_skid_vld = w_accept;
        w_skid_pkt = w_inc_pkt;
      end else begin
        w_out_vld  = w_accept;
        w_out_pkt  = w_inc_pkt;
      end
    end else if (w_accept) begin
      w_skid_vld = 1'b1;
      w_skid_pkt = w_inc_pkt;
    end
    if (flush) begin
      if (rob_is_younger(w_out_pkt.rob_entry_idx, flush_rob_idx, rob_head_idx))
        w_out_vld = 1'b0;
      if (rob_is_younger(w_skid_pkt.rob_entry_idx, flush_rob_idx, rob_head_idx))
        w_skid_vld = 1'b0;
    end
    if (!w_out_vld && w_skid_vld) begin
      w_out_vld  = 1'b1;
      w_out_pkt  = w_skid_pkt;
      w_skid_vld = 1'b0;
    end
  end

  // Stage boundary: output and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_pkt     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pkt   <= '0;
      r_iss_ready  <= 1'b1;
    end else begin
      r_ex_valid   <= w_out_vld;
      r_ex_pkt     <= w_out_pkt;
      r_skid_valid <= w_skid_vld;
      r_skid_pkt   <= w_skid_pkt;
      r_iss_ready  <= !w_skid_vld;
    end
  end

  assign iss_ready = r_iss_ready;
  assign ex_valid  = r_ex_valid;
  assign ex_pkt    = r_ex_pkt;

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: directed vectors, queue-based output checking.
module tb_reg_read_stage;
  import backend_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 iss_valid;
  issue_packet_t        iss_pkt;
  logic                 iss_ready;
  logic [PREG_W-1:0]    prf_rs1_idx;
  logic [XLEN-1:0]      prf_rs1_val;
  logic [PREG_W-1:0]    prf_rs2_idx;
  logic [XLEN-1:0]      prf_rs2_val;
  logic                 fwd_valid;
  logic [PREG_W-1:0]    fwd_dst;
  logic [XLEN-1:0]      fwd_val;
  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_dst;
  logic [XLEN-1:0]      wb_val;
  logic                 flush;
  logic [ROB_IDX_W-1:0] flush_rob_idx;
  logic [ROB_IDX_W-1:0] rob_head_idx;
  logic                 ex_ready;
  logic                 ex_valid;
  exec_packet_t         ex_pkt;

  logic [XLEN-1:0] prf_mem [64];
  exec_packet_t    exp_q [$];
  int total = 0;
  int bad   = 0;

  assign prf_rs1_val = prf_mem[prf_rs1_idx];
  assign prf_rs2_val = prf_mem[prf_rs2_idx];

  reg_read_stage dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_pkt(iss_pkt), .iss_ready(iss_ready),
    .prf_rs1_idx(prf_rs1_idx), .prf_rs1_val(prf_rs1_val),
    .prf_rs2_idx(prf_rs2_idx), .prf_rs2_val(prf_rs2_val),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_val(fwd_val),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_val(wb_val),
    .flush(flush), .flush_rob_idx(flush_rob_idx), .rob_head_idx(rob_head_idx),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pkt(ex_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_packet_t mk_iss(input logic [PREG_W-1:0] s1, input logic [PREG_W-1:0] s2,
                                           input logic u1, input logic u2,
                                           input logic [ROB_IDX_W-1:0] rob);
    issue_packet_t p;
    p.src1_preg     = s1;
    p.src2_preg     = s2;
    p.src1_used     = u1;
    p.src2_used     = u2;
    p.dst_preg      = PREG_W'(rob) + 6'd20;
    p.imm_val       = 32'h100 + XLEN'(rob);
    p.pc            = 32'h1000 + (XLEN'(rob) << 2);
    p.opcode        = 7'h33;
    p.alu_en        = 1'b1;
    p.br_taken      = rob[0];
    p.rob_entry_idx = rob;
    return p;
  endfunction

  function automatic exec_packet_t mk_exp(input issue_packet_t p, input logic [XLEN-1:0] v1,
                                          input logic [XLEN-1:0] v2);
    exec_packet_t e;
    e.src1_val      = v1;
    e.src2_val      = v2;
    e.imm_val       = p.imm_val;
    e.pc            = p.pc;
    e.opcode        = p.opcode;
    e.alu_en        = p.alu_en;
    e.br_taken      = p.br_taken;
    e.dst_preg      = p.dst_preg;
    e.rob_entry_idx = p.rob_entry_idx;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a uop until accepted (bounded); push its expected result on acceptance.
  task automatic issue(input issue_packet_t p, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2);
    bit ok;
    ok = 1'b0;
    iss_valid = 1'b1;
    iss_pkt   = p;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (iss_ready) begin
        ok = 1'b1;
        exp_q.push_back(mk_exp(p, v1, v2));
        break;
      end
      step();
    end
    step();
    iss_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL issue_accept: rob %0d got no iss_ready want accept", p.rob_entry_idx);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic flush_pulse(input logic [ROB_IDX_W-1:0] fidx);
    flush_rob_idx = fidx;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Monitor: every transfer into execute pops and compares one expected packet.
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got rob %0d src1 %0h want no output", ex_pkt.rob_entry_idx,
                 ex_pkt.src1_val);
      end else begin
        exec_packet_t e;
        e = exp_q.pop_front();
        if (ex_pkt !== e) begin
          bad++;
          $display("FAIL out_pkt: got rob %0d src1 %0h src2 %0h dst %0d want rob %0d src1 %0h src2 %0h dst %0d",
                   ex_pkt.rob_entry_idx, ex_pkt.src1_val, ex_pkt.src2_val, ex_pkt.dst_preg,
                   e.rob_entry_idx, e.src1_val, e.src2_val, e.dst_preg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) prf_mem[i] = 32'hA000 + i;
    prf_mem[0] = 32'hDEAD;
    prf_mem[5] = 32'h11;
    prf_mem[6] = 32'h22;
    prf_mem[7] = 32'h1;
    rst = 1'b0; iss_valid = 1'b0; iss_pkt = '0;
    fwd_valid = 1'b0; fwd_dst = '0; fwd_val = '0;
    wb_valid = 1'b0; wb_dst = '0; wb_val = '0;
    flush = 1'b0; flush_rob_idx = '0; rob_head_idx = '0; ex_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_iss_ready", 64'(iss_ready), 64'd1);
    chk("rst_ex_pkt", 64'(ex_pkt.src1_val) | 64'(ex_pkt.rob_entry_idx) | 64'(ex_pkt.pc), 64'd0);
    step();
    rst = 1'b0;

    // Back-to-back, no stall
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd0), 32'h11, 32'h22);
    @(negedge clk);
    chk("lat_ex_valid", 64'(ex_valid), 64'd1);
    step();
    issue(mk_iss(6'd6, 6'd5, 1'b1, 1'b1, 5'd1), 32'h22, 32'h11);
    wait_drain("b2b_drain");

    // Bypass priority
    wb_valid = 1'b1; wb_dst = 6'd7; wb_val = 32'h2;
    fwd_valid = 1'b1; fwd_dst = 6'd7; fwd_val = 32'h3;
    issue(mk_iss(6'd7, 6'd9, 1'b1, 1'b0, 5'd2), 32'h3, 32'h0);
    fwd_valid = 1'b0;
    issue(mk_iss(6'd7, 6'd5, 1'b1, 1'b1, 5'd3), 32'h2, 32'h11);
    fwd_valid = 1'b1; fwd_dst = 6'd0; fwd_val = 32'h55;
    wb_dst = 6'd0; wb_val = 32'h66;
    issue(mk_iss(6'd0, 6'd7, 1'b1, 1'b1, 5'd4), 32'h0, 32'h1);
    fwd_valid = 1'b0; wb_valid = 1'b0;
    wait_drain("byp_drain");

    // Stall / skid with A, B, C
    ex_ready = 1'b0;
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd5), 32'h11, 32'h22);
    issue(mk_iss(6'd6, 6'd6, 1'b1, 1'b1, 5'd6), 32'h22, 32'h22);
    iss_valid = 1'b1;
    iss_pkt = mk_iss(6'd5, 6'd5, 1'b1, 1'b1, 5'd7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_iss_ready", 64'(iss_ready), 64'd0);
      chk("stall_out_rob", 64'(ex_pkt.rob_entry_idx), 64'd5);
      step();
    end
    ex_ready = 1'b1;
    issue(mk_iss(6'd5, 6'd5, 1'b1, 1'b1, 5'd7), 32'h11, 32'h11);
    wait_drain("stall_drain");
    @(negedge clk);
    chk("stall_idle", 64'(ex_valid), 64'd0);
    step();

    // Flush filtering: out 4 kept, skid 6 and incoming 7 dropped
    rob_head_idx = 5'd0;
    ex_ready = 1'b0;
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd4), 32'h11, 32'h22);
    issue(mk_iss(6'd6, 6'd5, 1'b1, 1'b1, 5'd6), 32'h22, 32'h11);
    iss_valid = 1'b1;
    iss_pkt = mk_iss(6'd5, 6'd5, 1'b1, 1'b1, 5'd7);
    flush_pulse(5'd5);
    iss_valid = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_out_valid", 64'(ex_valid), 64'd1);
    chk("flush_out_rob", 64'(ex_pkt.rob_entry_idx), 64'd4);
    chk("flush_iss_ready", 64'(iss_ready), 64'd1);
    step();
    ex_ready = 1'b1;
    wait_drain("flush_drain");
    @(negedge clk);
    chk("flush_skid_gone", 64'(ex_valid), 64'd0);
    step();

    // Incoming uop younger than a same-cycle flush is not captured
    iss_valid = 1'b1;
    iss_pkt = mk_iss(6'd5, 6'd5, 1'b1, 1'b1, 5'd9);
    flush_rob_idx = 5'd5;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_inc_ready", 64'(iss_ready), 64'd1);
    step();
    flush = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    chk("flush_inc_dropped", 64'(ex_valid), 64'd0);
    step();

    // Wrap flush: head 30, branch 31
    rob_head_idx = 5'd30;
    ex_ready = 1'b0;
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd1), 32'h11, 32'h22);
    flush_pulse(5'd31);
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("wrap_idx1_dropped", 64'(ex_valid), 64'd0);
    step();
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd29), 32'h11, 32'h22);
    flush_pulse(5'd31);
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("wrap_idx29_dropped", 64'(ex_valid), 64'd0);
    step();
    issue(mk_iss(6'd6, 6'd5, 1'b1, 1'b1, 5'd31), 32'h22, 32'h11);
    flush_pulse(5'd31);
    @(negedge clk);
    chk("wrap_idx31_kept", 64'(ex_valid), 64'd1);
    chk("wrap_idx31_rob", 64'(ex_pkt.rob_entry_idx), 64'd31);
    step();
    ex_ready = 1'b1;
    wait_drain("wrap_drain");
    rob_head_idx = 5'd0;

    // Async reset mid-stall
    ex_ready = 1'b0;
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd10), 32'h11, 32'h22);
    issue(mk_iss(6'd5, 6'd6, 1'b1, 1'b1, 5'd11), 32'h11, 32'h22);
    @(negedge clk);
    chk("pre_rst_ready", 64'(iss_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("async_rst_iss_ready", 64'(iss_ready), 64'd1);
    exp_q.delete();
    step();
    rst = 1'b0;
    ex_ready = 1'b1;
    issue(mk_iss(6'd6, 6'd7, 1'b1, 1'b1, 5'd12), 32'h22, 32'h1);
    wait_drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
